serial_subtractor: RTL and testbench

//  Bit-serial N-bit unsigned subtractor computing diff = a - b, bout = borrow-out (a < b).

---
 rtl/serial_arith_pkg.sv | 20 ++
 rtl/serial_subtractor_if.sv | 24 ++
 rtl/full_subtractor.sv | 16 +
 rtl/serial_subtractor.sv | 108 ++++++++++
 tb/tb_serial_subtractor.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic blocks.
// Contents: controller state encoding (2-bit) and the bit-counter width helper.
// No logic; imported by the serial datapath modules.
package serial_arith_pkg;

  // Controller states, 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Bit counter width: enough to count 0..width-1, never narrower than 1 bit.
  function automatic int cnt_w(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake plus operand and result buses of the serial subtractor.
// master: controller drives start/a/b and observes busy/done/diff/bout.
// slave : subtractor consumes start/a/b and drives busy/done/diff/bout.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, bout
  );
endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor: diff_o = a_i - b_i - bin_i, bout_o = borrow out.
// Ports: a_i, b_i, bin_i in; diff_o, bout_o out. Purely combinational, zero latency.
// No handshake; the surrounding sequencer owns all timing.
module full_subtractor (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic diff_o,
  output logic bout_o
);

  assign diff_o = a_i ^ b_i ^ bin_i;
  // Borrow when b exceeds a, or when a == b and a borrow is coming in.
  assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b mod 2^WIDTH, bout = (a < b), LSB first.
// Latency: start accepted at edge E0 -> done pulses between edges E0+WIDTH and E0+WIDTH+1.
// Backpressure: start is sampled only in IDLE; starts while busy are dropped, not queued.
// Ports: clk, rst (async, active-high); bus (slave): start/a/b in, busy/done/diff/bout out.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);

  localparam int            CW       = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic             fs_diff;
  logic             fs_bout;
  logic [WIDTH:0]   diff_cat;

  full_subtractor u_fs (
    .a_i    (a_sr_q[0]),
    .b_i    (b_sr_q[0]),
    .bin_i  (borrow_q),
    .diff_o (fs_diff),
    .bout_o (fs_bout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    // New result bit enters at the MSB; after WIDTH shifts bit 0 sits at diff[0].
    // Built as a concatenation so WIDTH=1 needs no special case.
    diff_cat = {fs_diff, diff_q};

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_sr_d   = bus.a;
          b_sr_d   = bus.b;
          borrow_d = 1'b0;
          cnt_d    = '0;
          diff_d   = '0;
          bout_d   = 1'b0;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        diff_d   = diff_cat[WIDTH:1];
        borrow_d = fs_bout;
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          bout_d  = fs_bout;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Both decoded straight from the registered state, so they cannot glitch.
  assign bus.busy = (state_q != ST_IDLE);
  assign bus.done = (state_q == ST_DONE);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: WIDTH=8 directed and random ops, WIDTH=3 exhaustive.
// A cycle-level reference (countdown + plain a-b arithmetic) is compared every negedge.
// Directed ops additionally pin latency, busy length and literal results.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) bus8 ();
  serial_subtractor_if #(.WIDTH(3)) bus3 ();

  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_subtractor #(.WIDTH(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // Reference: an accepted op occupies WIDTH+1 cycles (busy); the last of them is done.
  // Results are visible from the done cycle until the next accept.
  int         m8_rem = 0;
  logic [7:0] m8_res = '0;
  logic       m8_bo  = 1'b0;
  int         m3_rem = 0;
  logic [2:0] m3_res = '0;
  logic       m3_bo  = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m8_rem <= 0; m8_res <= '0; m8_bo <= 1'b0;
    end else if (m8_rem > 0) begin
      m8_rem <= m8_rem - 1;
    end else if (bus8.start) begin
      m8_rem <= 9;
      m8_res <= bus8.a - bus8.b;
      m8_bo  <= (bus8.a < bus8.b);
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m3_rem <= 0; m3_res <= '0; m3_bo <= 1'b0;
    end else if (m3_rem > 0) begin
      m3_rem <= m3_rem - 1;
    end else if (bus3.start) begin
      m3_rem <= 4;
      m3_res <= bus3.a - bus3.b;
      m3_bo  <= (bus3.a < bus3.b);
    end
  end

  always @(negedge clk) begin
    check("busy8", 32'(bus8.busy), 32'(m8_rem > 0));
    check("done8", 32'(bus8.done), 32'(m8_rem == 1));
    if (m8_rem <= 1) begin
      check("diff8", 32'(bus8.diff), 32'(m8_res));
      check("bout8", 32'(bus8.bout), 32'(m8_bo));
    end
    check("busy3", 32'(bus3.busy), 32'(m3_rem > 0));
    check("done3", 32'(bus3.done), 32'(m3_rem == 1));
    if (m3_rem <= 1) begin
      check("diff3", 32'(bus3.diff), 32'(m3_res));
      check("bout3", 32'(bus3.bout), 32'(m3_bo));
    end
  end

  // Wait (bounded) until dut8 shows done at a negedge.
  task automatic wait_done8(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus8.done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic count_done8(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus8.done) n++;
    end
  endtask

  // One-cycle start pulse with literal expectations on latency, busy length and result.
  task automatic run_op8(input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] ed, input logic eb);
    int edges;
    int nbusy;
    bit seen;
    @(negedge clk);
    bus8.a = av; bus8.b = bv; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    edges = 1; nbusy = 0; seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus8.busy) nbusy++;
      if (bus8.done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      edges++;
    end
    check("op8_done_seen", 32'(seen), 32'd1);
    check("op8_latency_edges", 32'(edges), 32'd9);
    check("op8_diff_literal", 32'(bus8.diff), 32'(ed));
    check("op8_bout_literal", 32'(bus8.bout), 32'(eb));
    @(negedge clk);
    check("op8_busy_cycles", 32'(nbusy), 32'd9);
    check("op8_idle_after", 32'(bus8.busy), 32'd0);
  endtask

  initial begin
    bit   seen;
    int   n;
    int   cyc;
    int   last;
    logic [2:0] g_d;
    logic       g_b;

    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
    bus3.start = 1'b0; bus3.a = '0; bus3.b = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_busy8", 32'(bus8.busy), 32'd0);
    check("rst_done8", 32'(bus8.done), 32'd0);
    check("rst_diff8", 32'(bus8.diff), 32'd0);
    check("rst_bout8", 32'(bus8.bout), 32'd0);
    #1 rst = 1'b0;

    // Directed literals.
    run_op8(8'd100, 8'd37,  8'd63,  1'b0);
    run_op8(8'd37,  8'd100, 8'hC1,  1'b1);
    run_op8(8'd0,   8'd1,   8'd255, 1'b1);
    run_op8(8'd255, 8'd255, 8'd0,   1'b0);

    // Start pulsed mid-op with other operands: dropped, single done.
    @(negedge clk);
    bus8.a = 8'd100; bus8.b = 8'd37; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (2) @(negedge clk);
    bus8.a = 8'd1; bus8.b = 8'd200; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0; bus8.a = 8'd9; bus8.b = 8'd9;
    wait_done8(seen);
    check("ign_done_seen", 32'(seen), 32'd1);
    check("ign_diff", 32'(bus8.diff), 32'd63);
    check("ign_bout", 32'(bus8.bout), 32'd0);
    count_done8(15, n);
    check("ign_extra_done", 32'(n), 32'd0);

    // Reset in the middle of the shift phase: abort, no done.
    @(negedge clk);
    bus8.a = 8'd200; bus8.b = 8'd50; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(bus8.busy), 32'd0);
    check("abort_done", 32'(bus8.done), 32'd0);
    check("abort_diff", 32'(bus8.diff), 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    count_done8(15, n);
    check("abort_no_done", 32'(n), 32'd0);
    run_op8(8'd5, 8'd3, 8'd2, 1'b0);

    // Start held high: done every 10 cycles.
    @(negedge clk);
    bus8.a = 8'd77; bus8.b = 8'd200; bus8.start = 1'b1;
    last = -1; n = 0;
    for (cyc = 0; cyc < 45; cyc++) begin
      @(negedge clk);
      if (bus8.done) begin
        if (last >= 0) check("held_period", 32'(cyc - last), 32'd10);
        last = cyc;
        n++;
      end
    end
    check("held_pulses", 32'(n), 32'd4);
    bus8.start = 1'b0;
    wait_done8(seen);
    check("held_tail_done", 32'(seen), 32'd1);
    @(negedge clk);

    // Random ops with start stretched and operands wiggled while busy.
    for (int k = 0; k < 30; k++) begin
      int hold;
      hold = $urandom_range(1, 3);
      bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.start = 1'b1;
      repeat (hold) @(negedge clk);
      bus8.start = 1'b0;
      bus8.a = 8'($urandom); bus8.b = 8'($urandom);
      wait_done8(seen);
      check("rnd_done_seen", 32'(seen), 32'd1);
      repeat ($urandom_range(1, 4)) @(negedge clk);
    end

    // Exhaustive WIDTH=3 against plain a-b arithmetic.
    for (int ai = 0; ai < 8; ai++) begin
      for (int bi = 0; bi < 8; bi++) begin
        bus3.a = 3'(ai); bus3.b = 3'(bi); bus3.start = 1'b1;
        @(negedge clk);
        bus3.start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
          if (bus3.done) begin
            seen = 1'b1;
            break;
          end
          @(negedge clk);
        end
        g_d = 3'(ai - bi);
        g_b = (ai < bi);
        check("w3_done_seen", 32'(seen), 32'd1);
        check("w3_diff", 32'(bus3.diff), 32'(g_d));
        check("w3_bout", 32'(bus3.bout), 32'(g_b));
        @(negedge clk);
      end
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
